lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store request initiator that drives the single-port 32-bit word-addressed data RAM black box from the core's memory stage. Accepts one byte/half/word load or store per transaction over a valid/ready handshake. Converts it into a word-aligned RAM request with a byte write mask and lane-replicated write data, and returns the extracted, sign- or zero-extended load result over a second valid/ready handshake. Only one transaction is outstanding at a time.

## Interface
- MEM_LATENCY, 1: cycles `mem_valid` is held per request; `mem_rdata` is sampled at the end of the last one (≥1).
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; high only in IDLE.
- in_wen  in  1  1 = store, 0 = load.
- in_addr  in  32  byte address.
- in_wdata  in  32  store data, right-justified.
- in_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- in_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- out_valid  out  1  response present.
- out_ready  in  1  consumer takes response.
- out_rdata  out  32  extended load data; 0 for stores and errors.
- out_err  out  1  request was illegal or misaligned; no RAM access made.
- mem_valid  out  1  RAM request active.
- mem_wen  out  1  RAM write.
- mem_addr  out  32  `{in_addr[31:2],2'b00}`.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte enables, bit i = byte lane i.
- mem_rdata  in  32  RAM read word, valid by the end of each `mem_valid` cycle.

## Operation
- States: IDLE, REQ, RESP. `in_ready = (state==IDLE)`.
- IDLE: on `in_valid && in_ready`, latch the request and compute `off = in_addr[1:0]`.
  - Legal request: load the `mem_*` registers and go to REQ with `cnt = MEM_LATENCY-1`.
  - Error (see below): set `out_err=1`, `out_rdata=0`, and go directly to RESP. `mem_valid` stays 0.
- REQ: `mem_valid=1` and the other `mem_*` outputs are held stable.
  - If `cnt != 0`, decrement `cnt`.
  - If `cnt == 0`: for loads, capture the formatted `mem_rdata` into `out_rdata`; for stores, set `out_rdata=0`. Clear `mem_valid` and go to RESP.
- RESP: `out_valid=1`, outputs held stable until `out_ready`. On `out_valid && out_ready`, go to IDLE. No new request is accepted in the same cycle.
- Store formatting:
  - byte: `wmask = 4'b0001<<off`, `wdata = {4{in_wdata[7:0]}}`.
  - half: `wmask = 4'b0011<<off`, `wdata = {2{in_wdata[15:0]}}`.
  - word: `wmask = 4'hF`, `wdata = in_wdata`.
  - For loads, `wmask = 0` and `wdata = 0`.
- Load formatting: `sh = mem_rdata >> (8*off)`. Byte takes `sh[7:0]` and half takes `sh[15:0]`, each extended per `in_unsigned`. Word takes `sh` unchanged.
- Errors:
  - `in_size==11` is always an error.
  - Misaligned accesses (half with `off[0]=1`; word with `off!=0`) are handled per Configuration.
- Reset, at any state: the next posedge forces IDLE, clears all outputs to 0, and clears `cnt`. A RAM request in flight is abandoned with no response. `in_ready` reads 1 from the cycle after reset deasserts.

## Timing
- Reset values: `in_ready=1` once out of reset (0 while `reset` is high); every other output is 0.
- All outputs are registered or decoded from state only. There is no combinational path from `in_*` or `mem_rdata` to any output.
- Legal transaction: accept at edge N. `mem_valid` is high for cycles N+1 … N+MEM_LATENCY. `out_valid` rises after edge N+MEM_LATENCY. With immediate `out_ready`, `in_ready` returns after edge N+MEM_LATENCY+1.
- Error transaction: `out_valid` is high the cycle after accept. `mem_valid` is never raised.
- Throughput: one transaction per MEM_LATENCY+2 cycles at best.
- `out_ready` low stalls in RESP indefinitely; `out_rdata` and `out_err` remain constant.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a misaligned half/word produces an error response (`out_err=1`, no RAM access).
- Not defined: a misaligned access is issued as a normal request.
  - Write mask: `(base_mask<<off) & 4'hF`. Lanes beyond byte 3 are dropped.
  - Write data: the same replication rule as aligned stores. A word store is not replicated, so its data is unshifted.
  - Read data: shifted right by `8*off` with zero fill above byte `3-off`, then extended per size.
  - `out_err` is 0.

## Test plan
- Aligned word store: `addr=0x80000004`, `wdata=0xDEADBEEF` → one `mem_valid` cycle with `mem_addr=0x80000004`, `wmask=F`, `wdata=0xDEADBEEF`. Response has `out_rdata=0`, `err=0`.
- Byte loads at `addr=0x80000003`, `mem_rdata=0x80FF7F01`: signed → `out_rdata=0xFFFFFF80`; unsigned → `0x00000080`.
- Half store at `addr=0x...2`, `wdata=0x1234ABCD` → `wmask=4'b1100`, `mem_wdata=0xABCDABCD`. Half signed load with `mem_rdata=0x9ABC0000` → `0xFFFF9ABC`.
- Misaligned word load at `off=1`:
  - With LSU_MISALIGN_TRAP_EN: `out_err=1` and `mem_valid` stays 0.
  - Without it: `mem_rdata=0x44332211` → `out_rdata=0x00443322`.
- Backpressure and latency: MEM_LATENCY=3, `out_ready` held low for 5 cycles → `mem_valid` high for exactly 3 cycles, then `out_valid` and data held stable for all 5 stalled cycles, and `in_ready` stays 0 throughout.
- Reset mid-REQ: assert `reset` during the second `mem_valid` cycle → all outputs are 0 after that edge, no `out_valid` is produced, and a fresh request after reset completes normally.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store request initiator for the single-port, word-addressed data RAM.
// One transaction is in flight at a time: IDLE -> REQ (MEM_LATENCY cycles) -> RESP,
// or IDLE -> RESP directly for requests rejected with an error.
// Optional feature: define LSU_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses into error responses; otherwise they are issued to the RAM as-is.
module lsu_mem_port #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic [1:0]  req_off;
    logic        req_mis;
    logic        req_err;
    logic [3:0]  req_base_mask;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic [31:0] ld_sh;
    logic [31:0] ld_ext;

    // Decode the incoming request into RAM mask/data and an error flag.
    always_comb begin
        req_off       = in_addr[1:0];
        req_mis       = ((in_size == 2'b01) && req_off[0]) ||
                        ((in_size == 2'b10) && (req_off != 2'b00));
        req_err       = (in_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err       = req_err || req_mis;
`endif
        req_base_mask = 4'b0000;
        req_wdata     = 32'h0;
        unique case (in_size)
            2'b00: begin
                req_base_mask = 4'b0001;
                req_wdata     = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                req_base_mask = 4'b0011;
                req_wdata     = {2{in_wdata[15:0]}};
            end
            2'b10: begin
                req_base_mask = 4'b1111;
                req_wdata     = in_wdata;
            end
            default: begin
                req_base_mask = 4'b0000;
                req_wdata     = 32'h0;
            end
        endcase
        // Lanes shifted past byte 3 fall off the 4-bit mask (misaligned issue).
        req_wmask = req_base_mask << req_off;
        if (!in_wen) begin
            req_wmask = 4'b0000;
            req_wdata = 32'h0;
        end
    end

    // Shift the RAM word down to the addressed byte and extend per latched size.
    always_comb begin
        ld_sh  = mem_rdata >> {off_q, 3'b000};
        ld_ext = ld_sh;
        unique case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_sh[7]}}, ld_sh[7:0]};
            2'b01:   ld_ext = {{16{~uns_q & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    // Transaction FSM; every output is a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_rdata <= 32'h0;
            out_err   <= 1'b0;
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wmask <= 4'b0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        off_q    <= req_off;
                        size_q   <= in_size;
                        uns_q    <= in_unsigned;
                        if (req_err) begin
                            out_err   <= 1'b1;
                            out_rdata <= 32'h0;
                            out_valid <= 1'b1;
                            state_q   <= StResp;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_wen   <= in_wen;
                            mem_addr  <= {in_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                            mem_wmask <= req_wmask;
                            cnt_q     <= CntW'(MEM_LATENCY - 1);
                            state_q   <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        mem_valid <= 1'b0;
                        out_rdata <= mem_wen ? 32'h0 : ld_ext;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_rdata <= 32'h0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: expected RAM request and response are pushed
// when a request is driven, and checked when the DUT drives mem_valid / out_valid.
module tb_lsu_mem_port;

    localparam int unsigned LAT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    always #5 clock = ~clock;

    lsu_mem_port #(.MEM_LATENCY(LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wen      (in_wen),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rdata   (out_rdata),
        .out_err     (out_err),
        .mem_valid   (mem_valid),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_rdata   (mem_rdata)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   mem_cycles = 0;
    bit   mon_en     = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour, written lane by lane.
    function automatic exp_t model(input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [1:0] size,
                                   input logic uns, input logic [31:0] rdata);
        exp_t e;
        int   off;
        int   nb;
        logic mis;
        off = int'(addr[1:0]);
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'd0));
        e.err = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        e.err = e.err || mis;
`else
        mis = 1'b0;
`endif
        e.wen   = wen;
        e.addr  = {addr[31:2], 2'b00};
        e.wmask = 4'h0;
        e.wdata = 32'h0;
        e.rdata = 32'h0;
        if (!e.err && wen) begin
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + nb) e.wmask[i] = 1'b1;
            case (size)
                2'd0:    e.wdata = {4{wdata[7:0]}};
                2'd1:    e.wdata = {2{wdata[15:0]}};
                default: e.wdata = wdata;
            endcase
        end else if (!e.err) begin
            for (int j = 0; j < nb; j++)
                if (off + j < 4) e.rdata[8*j +: 8] = rdata[8*(off+j) +: 8];
            if (!uns && nb < 4 && e.rdata[8*nb-1])
                for (int j = nb; j < 4; j++) e.rdata[8*j +: 8] = 8'hFF;
        end
        return e;
    endfunction

    // Monitor: RAM request contents, REQ-phase in_ready, and responses.
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (mem_valid) begin
                mem_cycles++;
                check("in_ready_in_req", 32'(in_ready), 32'd0);
                if (sb.size() == 0) begin
                    check("mem_unexpected", 32'(mem_valid), 32'd0);
                end else begin
                    check("mem_on_err", 32'(mem_valid), 32'(!sb[0].err));
                    check("mem_addr", mem_addr, sb[0].addr);
                    check("mem_wen", 32'(mem_wen), 32'(sb[0].wen));
                    check("mem_wmask", 32'(mem_wmask), 32'(sb[0].wmask));
                    check("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_rdata", out_rdata, e.rdata);
                    check("out_err", 32'(out_err), 32'(e.err));
                    check("mem_cycles", 32'(mem_cycles), e.err ? 32'd0 : 32'(LAT));
                end
                mem_cycles = 0;
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clock);
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [31:0] rdata);
        @(negedge clock);
        wait_ready();
        in_wen      = wen;
        in_addr     = addr;
        in_wdata    = wdata;
        in_size     = size;
        in_unsigned = uns;
        mem_rdata   = rdata;
        in_valid    = 1'b1;
        sb.push_back(model(wen, addr, wdata, size, uns, rdata));
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_wen      = 1'b0;
        in_addr     = 32'h0;
        in_wdata    = 32'h0;
        in_size     = 2'd0;
        in_unsigned = 1'b0;
        out_ready   = 1'b1;
        mem_rdata   = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outs", out_rdata | mem_addr | mem_wdata | 32'(mem_wmask), 32'd0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed cases.
        send(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0);  drain();
        send(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80FF_7F01); drain();
        send(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h80FF_7F01); drain();
        send(1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'd1, 1'b0, 32'h0);  drain();
        send(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'h9ABC_0000); drain();
        send(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 32'h4433_2211); drain();
        send(1'b1, 32'h8000_0003, 32'hCAFE_F00D, 2'd1, 1'b0, 32'h0);  drain();
        send(1'b0, 32'h0000_0010, 32'h0, 2'd3, 1'b0, 32'h1234_5678); drain();

        // Backpressure: response must hold for 5 stalled cycles.
        out_ready = 1'b0;
        send(1'b0, 32'h0000_0021, 32'h0, 2'd0, 1'b0, 32'h0000_F000);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clock);
        check("bp_out_valid_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            if (sb.size() != 0) check("bp_rdata", out_rdata, sb[0].rdata);
        end
        out_ready = 1'b1;
        drain();

        // Reset during the second mem_valid cycle abandons the request.
        mon_en = 1'b0;
        @(negedge clock);
        wait_ready();
        in_wen = 1'b0; in_addr = 32'h40; in_size = 2'd2; in_unsigned = 1'b0;
        mem_rdata = 32'h5555_AAAA;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_req_mem_valid", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_outs", out_rdata | mem_addr | 32'(mem_wmask) | 32'(out_err), 32'd0);
        @(negedge clock) reset = 1'b0;
        mem_cycles = 0;
        sb.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("post_rst_no_resp", 32'(out_valid), 32'd0);
        end
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(1'b0, 32'h0000_0046, 32'h0, 2'd1, 1'b1, 32'hBEEF_0000); drain();

        // Random mix.
        for (int n = 0; n < 24; n++) begin
            send(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom);
            drain();
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
